rr_mux_sel_arbiter: RTL and testbench



---
 rtl/rr_mux_sel_arbiter.sv | 138 +++++++++++++
 tb/tb_rr_mux_sel_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_sel_arbiter.sv
// rtl/rr_mux_sel_arbiter.sv - round-robin arbiter owning the select of a shared 8:1 single-bit mux
module rr_mux_sel_arbiter #(
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   input  logic [7:0] I,
   output logic [7:0] gnt,
   output logic [2:0] S,
   output logic       busy,
   output logic       Y
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // MAX_HOLD fits the 4-bit hold counter over its whole legal range (1..15).
   localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

   state_t     state_q, state_d;
   logic [2:0] ptr_q, ptr_d;
   logic [3:0] hold_cnt_q, hold_cnt_d;
   logic [7:0] gnt_q, gnt_d;
   logic [2:0] s_q, s_d;
   logic       busy_q, busy_d;

   logic [2:0] arb_base;
   logic       arb_found;
   logic [2:0] arb_winner;
   logic       release_grant;

   // Priority base: stored pointer when idle, the slot after the current owner while granting.
   always_comb begin
      arb_base = ptr_q;
      if (state_q == GRANT) begin
         arb_base = s_q + 3'd1;
      end
   end

   // Rotating priority scan; walking offsets high-to-low leaves the nearest requester as winner.
   always_comb begin
      arb_found  = 1'b0;
      arb_winner = arb_base;
      for (int k = 7; k >= 0; k--) begin
         if (req[arb_base + 3'(k)]) begin
            arb_found  = 1'b1;
            arb_winner = arb_base + 3'(k);
         end
      end
   end

   // The owner gives up the mux when it stops asking or has used its full hold budget.
   always_comb begin
      release_grant = (req[s_q] == 1'b0) || (hold_cnt_q == HOLD_LIMIT);
   end

   // Next-state and next-output logic for the IDLE/GRANT machine.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      hold_cnt_d = hold_cnt_q;
      gnt_d      = gnt_q;
      s_d        = s_q;
      busy_d     = busy_q;

      case (state_q)
         IDLE: begin
            if (arb_found) begin
               state_d    = GRANT;
               gnt_d      = 8'(1) << arb_winner;
               s_d        = arb_winner;
               busy_d     = 1'b1;
               hold_cnt_d = 4'd1;
            end else begin
               gnt_d      = 8'h00;
               busy_d     = 1'b0;
               hold_cnt_d = 4'd0;
            end
         end

         GRANT: begin
            if (release_grant) begin
               ptr_d = s_q + 3'd1;
               if (arb_found) begin
                  // Handover in the same cycle, so the mux never sits idle between owners.
                  gnt_d      = 8'(1) << arb_winner;
                  s_d        = arb_winner;
                  busy_d     = 1'b1;
                  hold_cnt_d = 4'd1;
               end else begin
                  // S keeps the last owner; Y is gated by busy so the stale select is harmless.
                  state_d    = IDLE;
                  gnt_d      = 8'h00;
                  busy_d     = 1'b0;
                  hold_cnt_d = 4'd0;
               end
            end else begin
               hold_cnt_d = hold_cnt_q + 4'd1;
            end
         end

         default: begin
            state_d    = IDLE;
            gnt_d      = 8'h00;
            busy_d     = 1'b0;
            hold_cnt_d = 4'd0;
         end
      endcase
   end

   // State and output registers with synchronous reset; reset drops any grant in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         ptr_q      <= 3'd0;
         hold_cnt_q <= 4'd0;
         gnt_q      <= 8'h00;
         s_q        <= 3'd0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         hold_cnt_q <= hold_cnt_d;
         gnt_q      <= gnt_d;
         s_q        <= s_d;
         busy_q     <= busy_d;
      end
   end

   assign gnt  = gnt_q;
   assign S    = s_q;
   assign busy = busy_q;
   assign Y    = busy_q ? I[s_q] : 1'b0;

endmodule

// File: tb/tb_rr_mux_sel_arbiter.sv
// tb/tb_rr_mux_sel_arbiter.sv - self-checking bench for rr_mux_sel_arbiter
module tb_rr_mux_sel_arbiter;

   typedef struct packed {
      logic [7:0] gnt;
      logic [2:0] s;
      logic       busy;
      logic       y;
   } exp_t;

   logic       clk;
   logic       rst;
   logic [7:0] req;
   logic [7:0] I;
   logic [7:0] gnt;
   logic [2:0] S;
   logic       busy;
   logic       Y;

   exp_t exp_q[$];
   int   checks;
   int   errors;

   rr_mux_sel_arbiter #(.MAX_HOLD(4)) dut (
      .clk  (clk),
      .rst  (rst),
      .req  (req),
      .I    (I),
      .gnt  (gnt),
      .S    (S),
      .busy (busy),
      .Y    (Y)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Global time bound
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got running, need finished");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      req = 8'h00;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      exp_t e;
      I   = 8'hFF;
      rst = 1'b1;
      req = 8'hFF;
      for (int k = 0; k < 4; k++) begin
         if (k == 2) begin
            rst = 1'b0;
            req = 8'h00;
         end
         exp_q.push_back(exp_t'({8'h00, 3'd0, 1'b0, 1'b0}));
         tick();
         e = exp_q.pop_front();
         checks++;
         if ({gnt, S, busy, Y} !== e) begin
            errors++;
            $display("FAIL reset step %0d: got gnt=%h S=%0d busy=%b Y=%b, need gnt=%h S=%0d busy=%b Y=%b",
                     k, gnt, S, busy, Y, e.gnt, e.s, e.busy, e.y);
         end
      end
   endtask

   task automatic test_single_hold();
      exp_t e;
      apply_reset();
      I = 8'b0000_0011;
      for (int k = 0; k < 10; k++) begin
         if (k < 9) begin
            req = 8'h02;
            exp_q.push_back(exp_t'({8'h02, 3'd1, 1'b1, 1'b1}));
         end else begin
            req = 8'h00;
            exp_q.push_back(exp_t'({8'h00, 3'd1, 1'b0, 1'b0}));
         end
         tick();
         e = exp_q.pop_front();
         checks++;
         if ({gnt, S, busy, Y} !== e) begin
            errors++;
            $display("FAIL single_hold step %0d: got gnt=%h S=%0d busy=%b Y=%b, need gnt=%h S=%0d busy=%b Y=%b",
                     k, gnt, S, busy, Y, e.gnt, e.s, e.busy, e.y);
         end
      end
   endtask

   task automatic test_round_robin();
      exp_t       e;
      logic [2:0] gi;
      apply_reset();
      I = 8'h11;
      for (int k = 0; k < 17; k++) begin
         if (k < 16) begin
            req = 8'h91;
            case (k / 4)
               0, 3:    gi = 3'd0;
               1:       gi = 3'd4;
               default: gi = 3'd7;
            endcase
            exp_q.push_back(exp_t'({8'(1) << gi, gi, 1'b1, I[gi]}));
         end else begin
            req = 8'h00;
            exp_q.push_back(exp_t'({8'h00, 3'd0, 1'b0, 1'b0}));
         end
         tick();
         e = exp_q.pop_front();
         checks++;
         if ({gnt, S, busy, Y} !== e) begin
            errors++;
            $display("FAIL round_robin step %0d: got gnt=%h S=%0d busy=%b Y=%b, need gnt=%h S=%0d busy=%b Y=%b",
                     k, gnt, S, busy, Y, e.gnt, e.s, e.busy, e.y);
         end
      end
   endtask

   task automatic test_early_release();
      exp_t        e;
      logic [7:0]  rq [0:4];
      logic [12:0] ex [0:4];
      apply_reset();
      I  = 8'h68;
      rq = '{8'h08, 8'h28, 8'h20, 8'h00, 8'h41};
      ex = '{{8'h08, 3'd3, 1'b1, 1'b1},
             {8'h08, 3'd3, 1'b1, 1'b1},
             {8'h20, 3'd5, 1'b1, 1'b1},
             {8'h00, 3'd5, 1'b0, 1'b0},
             {8'h40, 3'd6, 1'b1, 1'b1}};
      for (int k = 0; k < 5; k++) begin
         req = rq[k];
         exp_q.push_back(exp_t'(ex[k]));
         tick();
         e = exp_q.pop_front();
         checks++;
         if ({gnt, S, busy, Y} !== e) begin
            errors++;
            $display("FAIL early_release step %0d: got gnt=%h S=%0d busy=%b Y=%b, need gnt=%h S=%0d busy=%b Y=%b",
                     k, gnt, S, busy, Y, e.gnt, e.s, e.busy, e.y);
         end
      end
   endtask

   task automatic test_wrap();
      exp_t e;
      apply_reset();
      I = 8'h80;
      for (int k = 0; k < 10; k++) begin
         req = (k == 0) ? 8'h80 : 8'h81;
         if (k >= 4 && k < 8) begin
            exp_q.push_back(exp_t'({8'h01, 3'd0, 1'b1, 1'b0}));
         end else begin
            exp_q.push_back(exp_t'({8'h80, 3'd7, 1'b1, 1'b1}));
         end
         tick();
         e = exp_q.pop_front();
         checks++;
         if ({gnt, S, busy, Y} !== e) begin
            errors++;
            $display("FAIL wrap step %0d: got gnt=%h S=%0d busy=%b Y=%b, need gnt=%h S=%0d busy=%b Y=%b",
                     k, gnt, S, busy, Y, e.gnt, e.s, e.busy, e.y);
         end
      end
   endtask

   task automatic test_reset_mid_grant();
      exp_t        e;
      logic [7:0]  rq [0:2];
      logic        rs [0:2];
      logic [12:0] ex [0:2];
      apply_reset();
      I  = 8'h41;
      rq = '{8'h40, 8'h40, 8'h41};
      rs = '{1'b0, 1'b1, 1'b0};
      ex = '{{8'h40, 3'd6, 1'b1, 1'b1},
             {8'h00, 3'd0, 1'b0, 1'b0},
             {8'h01, 3'd0, 1'b1, 1'b1}};
      for (int k = 0; k < 3; k++) begin
         req = rq[k];
         rst = rs[k];
         exp_q.push_back(exp_t'(ex[k]));
         tick();
         e = exp_q.pop_front();
         checks++;
         if ({gnt, S, busy, Y} !== e) begin
            errors++;
            $display("FAIL reset_mid_grant step %0d: got gnt=%h S=%0d busy=%b Y=%b, need gnt=%h S=%0d busy=%b Y=%b",
                     k, gnt, S, busy, Y, e.gnt, e.s, e.busy, e.y);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      req    = 8'h00;
      I      = 8'h00;
      test_reset();
      test_single_hold();
      test_round_robin();
      test_early_release();
      test_wrap();
      test_reset_mid_grant();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
